mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit data-memory words (power of two).
REQ-002 Parameter AW, default 8, word-index width = log2(DEPTH); memory index is iMemAdd[AW+1:2].
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 res  in  1  reset; synchronous and active-high.
REQ-005 iMemAdd  in  32  ALU result from EX/MEM: memory byte address, or write-back value.
REQ-006 iMemData  in  32  store data.
REQ-007 iRegDest  in  5  destination register number.
REQ-008 iNextInst  in  32  branch target computed in EX.
REQ-009 ibranch, izero  in  1 each  branch instruction flag; ALU zero flag.
REQ-010 iMemRead, iMemWrite  in  1 each  load request; store request.
REQ-011 iRegWrite, iMemtoReg  in  1 each  write-back enable; write-back source select (1 = memory).
REQ-012 istall  in  1  hazard-unit hold request.
REQ-013 oReadData  out  32  registered load data.
REQ-014 oAluResult  out  32  registered copy of iMemAdd.
REQ-015 oRegDest  out  5  registered destination register.
REQ-016 oRegWrite, oMemtoReg  out  1 each  registered write-back controls.
REQ-017 oPCSrc  out  1  registered branch-taken flag.
REQ-018 oBranchTarget  out  32  registered iNextInst.
REQ-019 oMisalign  out  1  registered misaligned-access flag.

Function
REQ-020 Data memory: DEPTH x 32 array; address bits above AW+1 ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-021 Aligned access: iMemAdd[1:0] == 0; otherwise the access is misaligned.
REQ-022 Store: on clk edge with iMemWrite=1, aligned, istall=0, res=0, mem[index] <= iMemData; all other edges leave memory unchanged.
REQ-023 Load: on an advancing edge, oReadData <= mem[index] if iMemRead=1 and aligned; otherwise oReadData <= 0.
REQ-024 Read-during-write to the same index in one cycle: oReadData returns the pre-write contents; the new value is visible from the next access.
REQ-025 iMemRead=1 and iMemWrite=1 together: the store executes per REQ-022 and the load returns old data per REQ-024.
REQ-026 Advancing edge (res=0, istall=0): oAluResult<=iMemAdd, oRegDest<=iRegDest, oMemtoReg<=iMemtoReg, oBranchTarget<=iNextInst, oPCSrc<=ibranch&izero.
REQ-027 oRegWrite <= iRegWrite & ~(iMemRead & misaligned).
REQ-028 oMisalign <= (iMemRead | iMemWrite) & misaligned; it is set for exactly one advancing cycle per offending access.
REQ-029 Misaligned store: memory write suppressed; no other side effect.
REQ-030 Stall (istall=1, res=0): every output register holds its value; memory write suppressed.
REQ-031 Latency: inputs to outputs exactly 1 clock; no combinational path from inputs to outputs.

Reset
REQ-032 On res=1 at a clk edge, every output register clears to 0, including oPCSrc, oRegWrite, and oMisalign.
REQ-033 Reset has priority over istall and suppresses any memory write in the same cycle.
REQ-034 Memory array contents are not cleared by reset; contents are undefined until written.
REQ-035 Reset asserted mid-stall or mid-access discards the in-flight instruction; first edge after res deasserts is a normal advancing edge.

Verification
REQ-036 Store 0xDEADBEEF at 0x10, then load 0x10 next cycle -> oReadData=0xDEADBEEF, oMisalign=0, one cycle after the load.
REQ-037 Same cycle: store 0x11111111 to 0x20 (old content 0x0000ABCD) with iMemRead=1 -> oReadData=0x0000ABCD; a following load gives 0x11111111.
REQ-038 Load at 0x22 with iRegWrite=1 -> oReadData=0, oRegWrite=0, oMisalign=1 for one cycle. Store at 0x23 -> memory unchanged.
REQ-039 ibranch=1, izero=1, iNextInst=0x40 -> next cycle oPCSrc=1, oBranchTarget=0x40. With izero=0 -> oPCSrc=0.
REQ-040 istall=1 for 3 cycles with iMemWrite=1 -> outputs frozen and no memory change; then res=1 with istall=1 -> all outputs 0.
REQ-041 Address 0x400 with DEPTH=256 -> aliases to index 0; a store there is readable at address 0x0.

Source files
------------

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module   : mem_wb_stage
// Brief    : Data-memory access plus MEM/WB pipeline register with stall,
//            misalignment detection and branch-taken resolution.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] iMemAdd,
  input  logic [31:0] iMemData,
  input  logic [4:0]  iRegDest,
  input  logic [31:0] iNextInst,
  input  logic        ibranch,
  input  logic        izero,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic        iRegWrite,
  input  logic        iMemtoReg,
  input  logic        istall,
  output logic [31:0] oReadData,
  output logic [31:0] oAluResult,
  output logic [4:0]  oRegDest,
  output logic        oRegWrite,
  output logic        oMemtoReg,
  output logic        oPCSrc,
  output logic [31:0] oBranchTarget,
  output logic        oMisalign
);

  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] w_index;
  logic          w_misaligned;
  logic          w_advance;

  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  reg_dest_q, reg_dest_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        pc_src_q, pc_src_d;
  logic [31:0] branch_target_q, branch_target_d;
  logic        misalign_q, misalign_d;

  assign w_index      = iMemAdd[AW+1:2];
  assign w_misaligned = (iMemAdd[1:0] != 2'b00);
  assign w_advance    = ~istall;

  // Memory is read combinationally here but only ever observed through the
  // output register, so a same-index store returns the pre-write word.
  always_comb begin
    read_data_d     = read_data_q;
    alu_result_d    = alu_result_q;
    reg_dest_d      = reg_dest_q;
    reg_write_d     = reg_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    pc_src_d        = pc_src_q;
    branch_target_d = branch_target_q;
    misalign_d      = misalign_q;
    if (w_advance) begin
      read_data_d     = (iMemRead && !w_misaligned) ? mem_q[w_index] : 32'd0;
      alu_result_d    = iMemAdd;
      reg_dest_d      = iRegDest;
      reg_write_d     = iRegWrite & ~(iMemRead & w_misaligned);
      mem_to_reg_d    = iMemtoReg;
      pc_src_d        = ibranch & izero;
      branch_target_d = iNextInst;
      misalign_d      = (iMemRead | iMemWrite) & w_misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      read_data_q     <= 32'd0;
      alu_result_q    <= 32'd0;
      reg_dest_q      <= 5'd0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      pc_src_q        <= 1'b0;
      branch_target_q <= 32'd0;
      misalign_q      <= 1'b0;
    end else begin
      read_data_q     <= read_data_d;
      alu_result_q    <= alu_result_d;
      reg_dest_q      <= reg_dest_d;
      reg_write_q     <= reg_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      pc_src_q        <= pc_src_d;
      branch_target_q <= branch_target_d;
      misalign_q      <= misalign_d;
    end
  end

  // Array has no reset so it can map onto RAM macros.
  always_ff @(posedge clk) begin
    if (!res && w_advance && iMemWrite && !w_misaligned) begin
      mem_q[w_index] <= iMemData;
    end
  end

  assign oReadData     = read_data_q;
  assign oAluResult    = alu_result_q;
  assign oRegDest      = reg_dest_q;
  assign oRegWrite     = reg_write_q;
  assign oMemtoReg     = mem_to_reg_q;
  assign oPCSrc        = pc_src_q;
  assign oBranchTarget = branch_target_q;
  assign oMisalign     = misalign_q;

endmodule

`default_nettype wire
